// File: rtl/wb_uart_rx.sv
// wb_uart_rx: 8N1 serial receiver. Received bytes are buffered in a FIFO
// and read back through a single-cycle Wishbone responder.
// Registers: 0 RXDATA (read pops), 1 STATUS (W1C on the error bits),
// 2 CTRL (irq enable), 3 reserved.
module wb_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        i_rx,
    output logic        o_irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    rx_state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;

    logic          overrun;
    logic          frame_err;
    logic          irq_en;

    logic          stop_tick;
    logic          rx_push;
    logic          frame_set;
    logic          bus_req;
    logic [1:0]    reg_sel;
    logic          rd_pop;
    logic          do_push;
    logic          overrun_set;
    logic          status_w1c;
    logic          not_empty;
    logic          full;
    logic [31:0]   rd_mux;

    // Byte-select, unused address bits and unused write-data bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{i_wb_sel, i_wb_adr[31:4], i_wb_adr[1:0],
                             i_wb_dat[31:4], i_wb_dat[1]};

    // Two-flop synchroniser; resets to the idle-high line level so reset
    // release never looks like a start bit.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver FSM: start bit is qualified at its midpoint, after which every
    // later sample lands one full bit period on, i.e. mid-bit.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            rx_state <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= ST_START;
                        bit_cnt  <= '0;
                    end
                end
                ST_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt           <= '0;
                        rx_shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        rx_state <= ST_IDLE;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    // Stop-bit sample: a high stop bit delivers the byte, a low one is a framing error.
    assign stop_tick = (rx_state == ST_STOP) && (bit_cnt == BIT_LAST);
    assign rx_push   = stop_tick && rx_s;
    assign frame_set = stop_tick && !rx_s;

    // Wishbone handshake: a request is cyc & stb while no ack is outstanding;
    // it is accepted on that clock edge and completed by a one-cycle ack on
    // the next cycle, with rdt valid only while ack is high. A read of RXDATA
    // pops at the accepting edge, so rdt carries the pre-pop head.
    assign bus_req    = i_wb_cyc && i_wb_stb && !o_wb_ack;
    assign reg_sel    = i_wb_adr[3:2];
    assign not_empty  = (fifo_count != '0);
    assign full       = (fifo_count == FULL_CNT);
    assign rd_pop     = bus_req && !i_wb_we && (reg_sel == 2'd0) && not_empty;
    assign do_push    = rx_push && (!full || rd_pop);
    assign overrun_set = rx_push && full && !rd_pop;
    assign status_w1c = bus_req && i_wb_we && (reg_sel == 2'd1);

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge i_wb_clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= rx_shift;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, rd_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky error flags and control; a set event wins over a same-cycle clear.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            overrun   <= (overrun && !(status_w1c && i_wb_dat[2])) || overrun_set;
            frame_err <= (frame_err && !(status_w1c && i_wb_dat[3])) || frame_set;
            if (bus_req && i_wb_we && (reg_sel == 2'd2)) begin
                irq_en <= i_wb_dat[0];
            end
        end
    end

    // Read data mux over the current (pre-edge) register state.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0: begin
                if (not_empty) begin
                    rd_mux[7:0] = fifo_mem[rd_ptr];
                end
            end
            2'd1: begin
                rd_mux[0]     = not_empty;
                rd_mux[1]     = full;
                rd_mux[2]     = overrun;
                rd_mux[3]     = frame_err;
                rd_mux[24:16] = 9'(fifo_count);
            end
            2'd2: begin
                rd_mux[0] = irq_en;
            end
            default: rd_mux = '0;
        endcase
    end

    // Registered bus response and level interrupt.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            o_irq    <= 1'b0;
        end else begin
            o_wb_ack <= bus_req;
            o_wb_rdt <= (bus_req && !i_wb_we) ? rd_mux : 32'h0;
            o_irq    <= irq_en && not_empty;
        end
    end

endmodule

// File: tb/tb_wb_uart_rx.sv
// tb_wb_uart_rx: directed bench for wb_uart_rx with a queue-based model of
// the receive FIFO, flags and bus responses, checked every cycle.
module tb_wb_uart_rx;

    localparam int CPB      = 8;
    localparam int DEPTH    = 4;
    // Edge, counted from the edge before the start bit is driven, on which
    // the stop bit is sampled: 2 sync flops + idle detect, half a bit, 9 bits.
    localparam int PUSH_OFF = 3 + CPB / 2 + 9 * CPB;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = 4'hF;
    logic        we  = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        rx  = 1'b1;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_irq;

    always #5 clk = ~clk;

    wb_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_wb_clk(clk),
        .i_wb_rst(rst),
        .i_wb_adr(adr),
        .i_wb_dat(dat),
        .i_wb_sel(sel),
        .i_wb_we(we),
        .i_wb_cyc(cyc),
        .i_wb_stb(stb),
        .o_wb_rdt(o_wb_rdt),
        .o_wb_ack(o_wb_ack),
        .i_rx(rx),
        .o_irq(o_irq)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        bit         ferr;
        logic [7:0] data;
    } ev_t;

    logic [7:0]  exp_q[$];
    ev_t         ev_q[$];
    int          cyc_n = 0;
    bit          live = 0;
    bit          m_overrun = 0;
    bit          m_ferr = 0;
    bit          m_irq_en = 0;
    bit          m_ack = 0;
    bit          m_irq = 0;
    logic [31:0] m_rdt = '0;

    logic [31:0] rdv;
    logic [31:0] rdv2;
    logic        irq_at_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] status_word();
        logic [31:0] s;
        s        = '0;
        s[0]     = (exp_q.size() != 0);
        s[1]     = (exp_q.size() == DEPTH);
        s[2]     = m_overrun;
        s[3]     = m_ferr;
        s[24:16] = 9'(exp_q.size());
        return s;
    endfunction

    // Model: bus reads see pre-edge state; pop happens before push so a full
    // FIFO with a same-cycle read still accepts the byte; sets beat W1C clears.
    always @(posedge clk) begin
        bit          req;
        bit          pop;
        bit          push;
        bit          fe_set;
        bit          irq_next;
        logic [7:0]  pb;
        logic [31:0] rd;
        ev_t         ev;
        cyc_n++;
        if (rst) begin
            exp_q.delete();
            ev_q.delete();
            m_overrun = 0;
            m_ferr    = 0;
            m_irq_en  = 0;
            m_ack     = 0;
            m_irq     = 0;
            m_rdt     = '0;
            live      = 1;
        end else begin
            req      = cyc && stb && !m_ack;
            irq_next = m_irq_en && (exp_q.size() != 0);
            rd       = '0;
            pop      = 0;
            if (req && !we) begin
                case (adr[3:2])
                    2'd0: if (exp_q.size() != 0) begin
                        rd  = {24'h0, exp_q[0]};
                        pop = 1;
                    end
                    2'd1: rd = status_word();
                    2'd2: rd = {31'h0, m_irq_en};
                    default: rd = '0;
                endcase
            end
            push   = 0;
            fe_set = 0;
            pb     = '0;
            while (ev_q.size() != 0 && ev_q[0].cyc <= cyc_n) begin
                ev = ev_q.pop_front();
                if (ev.ferr) fe_set = 1;
                else begin
                    push = 1;
                    pb   = ev.data;
                end
            end
            if (pop) void'(exp_q.pop_front());
            if (req && we && adr[3:2] == 2'd1) begin
                if (dat[2]) m_overrun = 0;
                if (dat[3]) m_ferr = 0;
            end
            if (req && we && adr[3:2] == 2'd2) m_irq_en = dat[0];
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(pb);
                else m_overrun = 1;
            end
            if (fe_set) m_ferr = 1;
            m_ack = req;
            m_rdt = rd;
            m_irq = irq_next;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            chk("ack", {31'h0, o_wb_ack}, {31'h0, m_ack});
            chk("rdt", o_wb_rdt, m_rdt);
            chk("irq", {31'h0, o_irq}, {31'h0, m_irq});
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        n   = 0;
        cyc = 1'b1;
        stb = 1'b1;
        we  = w;
        adr = {28'h0, a, 2'b00};
        dat = d;
        do begin
            @(negedge clk);
            n++;
        end while (!o_wb_ack && n < 8);
        checks++;
        if (n != 1 || !o_wb_ack) begin
            errors++;
            $display("FAIL ack_latency got %0d cycles expected 1 (ack=%0b)", n, o_wb_ack);
        end
        r          = o_wb_rdt;
        irq_at_ack = o_irq;
        cyc        = 1'b0;
        stb        = 1'b0;
        we         = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int hold);
        ev_t ev;
        ev.cyc  = cyc_n + PUSH_OFF;
        ev.ferr = !stop;
        ev.data = b;
        ev_q.push_back(ev);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (hold) @(negedge clk);
        rx = 1'b1;
    endtask

    // Watchdog: the run is a few thousand cycles.
    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int tgt;
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        chk("reset_ack", {31'h0, o_wb_ack}, 32'h0);
        chk("reset_rdt", o_wb_rdt, 32'h0);
        chk("reset_irq", {31'h0, o_irq}, 32'h0);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("reset_status", rdv, 32'h0000_0000);

        // Single byte
        send_frame(8'hA5, 1'b1, CPB);
        idle(2);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("a5_status_before", rdv, 32'h0001_0001);
        bus(1'b0, 2'd0, 32'h0, rdv);
        chk("a5_data", rdv, 32'h0000_00A5);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("a5_status_after", rdv, 32'h0000_0000);

        // Interrupt
        bus(1'b1, 2'd2, 32'h1, rdv);
        bus(1'b0, 2'd2, 32'h0, rdv);
        chk("ctrl_read", rdv, 32'h0000_0001);
        send_frame(8'h3C, 1'b1, CPB);
        chk("irq_rise", {31'h0, o_irq}, 32'h1);
        bus(1'b0, 2'd0, 32'h0, rdv);
        chk("3c_data", rdv, 32'h0000_003C);
        chk("irq_at_ack", {31'h0, irq_at_ack}, 32'h1);
        chk("irq_fall", {31'h0, o_irq}, 32'h0);
        bus(1'b1, 2'd2, 32'h0, rdv);

        // Overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, CPB);
        idle(2);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("ovr_status", rdv, 32'h0004_0007);
        for (int i = 1; i <= 4; i++) begin
            bus(1'b0, 2'd0, 32'h0, rdv);
            chk("ovr_data", rdv, 32'(i));
        end
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("ovr_sticky", rdv, 32'h0000_0004);
        bus(1'b1, 2'd1, 32'h4, rdv);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("ovr_cleared", rdv, 32'h0000_0000);

        // Framing error with break, then a good byte
        send_frame(8'hF0, 1'b0, 40);
        idle(2 * CPB);
        send_frame(8'h55, 1'b1, CPB);
        idle(2);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("ferr_status", rdv, 32'h0001_0009);
        bus(1'b0, 2'd0, 32'h0, rdv);
        chk("ferr_next_data", rdv, 32'h0000_0055);
        bus(1'b1, 2'd1, 32'h8, rdv);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("ferr_cleared", rdv, 32'h0000_0000);

        // Short glitch
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(20);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("glitch_status", rdv, 32'h0000_0000);

        // Read while empty
        bus(1'b0, 2'd0, 32'h0, rdv);
        chk("empty_data", rdv, 32'h0000_0000);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("empty_status", rdv, 32'h0000_0000);

        // Pop on the same edge as a push into a full FIFO
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, CPB);
        idle(2);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("full_status", rdv, 32'h0004_0003);
        tgt = cyc_n + PUSH_OFF;
        fork
            send_frame(8'h15, 1'b1, CPB);
            begin
                while (cyc_n < tgt - 1) @(negedge clk);
                bus(1'b0, 2'd0, 32'h0, rdv2);
            end
        join
        chk("poppush_data", rdv2, 32'h0000_0011);
        idle(2);
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("poppush_status", rdv, 32'h0004_0003);
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, 2'd0, 32'h0, rdv);
            chk("poppush_drain", rdv, 32'h12 + 32'(i));
        end
        bus(1'b0, 2'd1, 32'h0, rdv);
        chk("final_status", rdv, 32'h0000_0000);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
